// File: rtl/bus_splitter_pkg.sv
// Shared types for the bus_splitter slice: FSM states, decode targets and
// the window-membership helper used by the address decoder.
package bus_splitter_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
    typedef enum logic [1:0] {TGT_A, TGT_B, TGT_NONE} tgt_e;

    // Window end is formed in 33 bits so a window reaching 2^32 cannot wrap.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [32:0] win_end;
        win_end = {1'b0, base} + {1'b0, size};
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < win_end);
    endfunction

endpackage

// File: rtl/bus_splitter_if.sv
// Avalon-MM style read/write bus; Host drives the request, Agent answers it.
interface AvalonMmRw;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;

    modport Host (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport Agent (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );

endinterface

// File: rtl/bus_splitter_addr_decode.sv
// Combinational address decoder: maps a full 32-bit address onto agent A,
// agent B or no target; A takes priority where the windows overlap.
module addr_decode
    import bus_splitter_pkg::*;
#(
    parameter logic [31:0] A_BASE = 32'h0000_0000,
    parameter logic [31:0] A_SIZE = 32'd8192,
    parameter logic [31:0] B_BASE = 32'h0001_0000,
    parameter logic [31:0] B_SIZE = 32'd256
) (
    input  logic [31:0] addr_i,
    output tgt_e        tgt_o
);

    always_comb begin
        tgt_o = TGT_NONE;
        if (in_window(addr_i, A_BASE, A_SIZE)) begin
            tgt_o = TGT_A;
        end else if (in_window(addr_i, B_BASE, B_SIZE)) begin
            tgt_o = TGT_B;
        end
    end

endmodule

// File: rtl/bus_splitter.sv
// One-host, two-agent bus splitter: latches a host request, forwards it to the
// decoded agent and returns a single-cycle completion; unmapped accesses error.
module bus_splitter
    import bus_splitter_pkg::*;
#(
    parameter logic [31:0] A_BASE   = 32'h0000_0000,
    parameter logic [31:0] A_SIZE   = 32'd8192,
    parameter logic [31:0] B_BASE   = 32'h0001_0000,
    parameter logic [31:0] B_SIZE   = 32'd256,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic      clk,
    input  logic      rst,
    AvalonMmRw.Agent  host,
    AvalonMmRw.Host   agent_a,
    AvalonMmRw.Host   agent_b,
    output logic      decode_err
);

    state_e      state_q, state_d;
    tgt_e        tgt_q, tgt_d, dec_tgt;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic        rd_q, rd_d;
    logic        tgt_wait;

    addr_decode #(
        .A_BASE (A_BASE),
        .A_SIZE (A_SIZE),
        .B_BASE (B_BASE),
        .B_SIZE (B_SIZE)
    ) u_decode (
        .addr_i (host.address),
        .tgt_o  (dec_tgt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tgt_q   <= TGT_A;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        rd_d    = rd_q;

        host.waitrequest   = 1'b1;
        host.readdata      = rdata_q;
        decode_err         = 1'b0;
        agent_a.address    = addr_q;
        agent_a.writedata  = wdata_q;
        agent_a.byteenable = be_q;
        agent_a.read       = 1'b0;
        agent_a.write      = 1'b0;
        agent_b.address    = addr_q;
        agent_b.writedata  = wdata_q;
        agent_b.byteenable = be_q;
        agent_b.read       = 1'b0;
        agent_b.write      = 1'b0;
        tgt_wait = (tgt_q == TGT_A) ? agent_a.waitrequest : agent_b.waitrequest;

        unique case (state_q)
            IDLE: begin
                // Read wins when both strobes are presented together.
                if (host.read || host.write) begin
                    addr_d  = host.address;
                    wdata_d = host.writedata;
                    be_d    = host.byteenable;
                    rd_d    = host.read;
                    tgt_d   = dec_tgt;
                    if (dec_tgt == TGT_NONE) begin
                        rdata_d = ERR_DATA;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                agent_a.read  = (tgt_q == TGT_A) &&  rd_q;
                agent_a.write = (tgt_q == TGT_A) && !rd_q;
                agent_b.read  = (tgt_q == TGT_B) &&  rd_q;
                agent_b.write = (tgt_q == TGT_B) && !rd_q;
                if (!tgt_wait) begin
                    if (rd_q) begin
                        rdata_d = (tgt_q == TGT_A) ? agent_a.readdata : agent_b.readdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                host.waitrequest = 1'b0;
                decode_err       = (tgt_q == TGT_NONE);
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_splitter.sv
// Scoreboard bench for bus_splitter: memory-backed agent responders, a
// reference memory/decode model, and a monitor that checks each completion.
`timescale 1ns/1ps
module tb_bus_splitter;

    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic decode_err;

    AvalonMmRw host_if();
    AvalonMmRw a_if();
    AvalonMmRw b_if();

    bus_splitter dut (
        .clk        (clk),
        .rst        (rst),
        .host       (host_if),
        .agent_a    (a_if),
        .agent_b    (b_if),
        .decode_err (decode_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic        is_rd;
        logic [31:0] rdata;
        int          tgt;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          strobes;
    } exp_t;

    typedef struct {
        int          tgt;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } acc_t;

    exp_t exp_q[$];
    acc_t acc_q[$];
    exp_t mon_e;
    acc_t mon_a;

    logic [31:0] mem_a [0:2047];
    logic [31:0] mem_b [0:63];
    logic [31:0] ref_a [0:2047];
    logic [31:0] ref_b [0:63];
    logic [31:0] edges [0:5];

    int wait_cycles = 0;
    int cnt_a = 0;
    int cnt_b = 0;
    int sa = 0;
    int sb = 0;

    function automatic logic [31:0] init_val(input int tgt, input int i);
        if (tgt == 0) return (i == 4) ? 32'h1234_5678 : (32'hA500_0000 | 32'(i * 7));
        return 32'hB0B0_0000 | 32'(i * 13);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    // Reference decode: 0 = A, 1 = B, 2 = unmapped.
    function automatic int ref_tgt(input logic [31:0] a);
        longint unsigned x;
        x = 64'(a);
        if (x < 64'h2000) return 0;
        if (x >= 64'h1_0000 && x < 64'h1_0100) return 1;
        return 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Agent responders: configurable waitrequest stretch, memory behind each window.
    assign a_if.waitrequest = (cnt_a < wait_cycles);
    assign b_if.waitrequest = (cnt_b < wait_cycles);
    assign a_if.readdata    = mem_a[a_if.address[12:2]];
    assign b_if.readdata    = mem_b[b_if.address[7:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2048; i++) mem_a[i] <= init_val(0, i);
            for (int i = 0; i < 64; i++) mem_b[i] <= init_val(1, i);
            cnt_a <= 0;
            cnt_b <= 0;
        end else begin
            cnt_a <= ((a_if.read || a_if.write) && a_if.waitrequest) ? cnt_a + 1 : 0;
            cnt_b <= ((b_if.read || b_if.write) && b_if.waitrequest) ? cnt_b + 1 : 0;
            if ((a_if.read || a_if.write) && !a_if.waitrequest) begin
                acc_q.push_back('{0, a_if.address, a_if.write, a_if.writedata, a_if.byteenable});
                if (a_if.write)
                    mem_a[a_if.address[12:2]] <= merge(mem_a[a_if.address[12:2]],
                                                       a_if.writedata, a_if.byteenable);
            end
            if ((b_if.read || b_if.write) && !b_if.waitrequest) begin
                acc_q.push_back('{1, b_if.address, b_if.write, b_if.writedata, b_if.byteenable});
                if (b_if.write)
                    mem_b[b_if.address[7:2]] <= merge(mem_b[b_if.address[7:2]],
                                                      b_if.writedata, b_if.byteenable);
            end
        end
    end

    // Monitor: invariants every cycle, scoreboard compare on each host completion.
    always @(negedge clk) begin
        if (rst) begin
            sa = 0;
            sb = 0;
        end else begin
            if (a_if.read || a_if.write) sa++;
            if (b_if.read || b_if.write) sb++;
            chk("both_agents_strobed", 32'((a_if.read || a_if.write) && (b_if.read || b_if.write)), 0);
            chk("strobe_during_completion",
                32'((a_if.read || a_if.write || b_if.read || b_if.write) && !host_if.waitrequest), 0);
            chk("decode_err_outside_completion", 32'(decode_err && host_if.waitrequest), 0);
            if ((host_if.read || host_if.write) && !host_if.waitrequest) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_rd) chk("readdata", host_if.readdata, mon_e.rdata);
                    chk("decode_err", 32'(decode_err), 32'(mon_e.tgt == 2));
                    chk("a_strobe_cycles", 32'(sa), 32'((mon_e.tgt == 0) ? mon_e.strobes : 0));
                    chk("b_strobe_cycles", 32'(sb), 32'((mon_e.tgt == 1) ? mon_e.strobes : 0));
                    chk("agent_accepts", 32'(acc_q.size()), 32'((mon_e.tgt == 2) ? 0 : 1));
                    if (mon_e.tgt != 2 && acc_q.size() > 0) begin
                        mon_a = acc_q.pop_front();
                        chk("accept_target", 32'(mon_a.tgt), 32'(mon_e.tgt));
                        chk("accept_addr", mon_a.addr, mon_e.addr);
                        chk("accept_is_write", 32'(mon_a.wr), 32'(!mon_e.is_rd));
                        if (!mon_e.is_rd) begin
                            chk("accept_wdata", mon_a.wdata, mon_e.wdata);
                            chk("accept_be", 32'(mon_a.be), 32'(mon_e.be));
                        end
                    end
                    acc_q.delete();
                end
                sa = 0;
                sb = 0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        host_if.read = 1'b0;
        host_if.write = 1'b0;
        host_if.address = '0;
        host_if.writedata = '0;
        host_if.byteenable = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        acc_q.delete();
        for (int i = 0; i < 2048; i++) ref_a[i] = init_val(0, i);
        for (int i = 0; i < 64; i++) ref_b[i] = init_val(1, i);
        @(negedge clk);
        chk("rst_waitrequest", 32'(host_if.waitrequest), 1);
        chk("rst_decode_err", 32'(decode_err), 0);
        chk("rst_a_strobe", 32'(a_if.read || a_if.write), 0);
        chk("rst_b_strobe", 32'(b_if.read || b_if.write), 0);
        chk("rst_readdata", host_if.readdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issue one transfer starting just after a rising edge; returns the same way.
    task automatic xfer(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] be, input int wt);
        exp_t e;
        int lat;
        int exp_lat;
        e.addr = addr; e.is_rd = rd; e.tgt = ref_tgt(addr);
        e.wdata = wdata; e.be = be; e.rdata = ERR; e.strobes = 1 + wt;
        if (rd) begin
            if (e.tgt == 0) e.rdata = ref_a[addr[12:2]];
            else if (e.tgt == 1) e.rdata = ref_b[addr[7:2]];
        end else begin
            if (e.tgt == 0) ref_a[addr[12:2]] = merge(ref_a[addr[12:2]], wdata, be);
            else if (e.tgt == 1) ref_b[addr[7:2]] = merge(ref_b[addr[7:2]], wdata, be);
        end
        wait_cycles = wt;
        host_if.address = addr;
        host_if.read = rd;
        host_if.write = wr;
        host_if.writedata = wdata;
        host_if.byteenable = be;
        exp_q.push_back(e);
        exp_lat = (e.tgt == 2) ? 1 : 2 + wt;
        lat = 0;
        while (1) begin
            @(negedge clk);
            if (!host_if.waitrequest) break;
            lat++;
            if (lat > 60) break;
        end
        if (lat > 60) begin
            chk("completion_timeout", 32'(lat), 32'(exp_lat));
            do_reset();
            return;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        @(posedge clk);
        #1;
        host_if.read = 1'b0;
        host_if.write = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int k;
        edges[0] = 32'h0000_0000; edges[1] = 32'h0000_1FFC; edges[2] = 32'h0000_2000;
        edges[3] = 32'h0000_FFFC; edges[4] = 32'h0001_00FC; edges[5] = 32'h0001_0100;
        do_reset();

        xfer(32'h0000_0010, 1'b1, 1'b0, 32'h0, 4'hF, 0);
        xfer(32'h0001_0004, 1'b0, 1'b1, 32'hA5A5_A5A5, 4'b0011, 3);
        xfer(32'h0001_0004, 1'b1, 1'b0, 32'h0, 4'hF, 0);
        xfer(32'h0000_2000, 1'b1, 1'b0, 32'h0, 4'hF, 0);
        xfer(32'h0000_2000, 1'b0, 1'b1, 32'h0BAD_0001, 4'hF, 0);
        for (int i = 0; i < 6; i++) xfer(edges[i], 1'b1, 1'b0, 32'h0, 4'hF, 1);
        xfer(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 4'hF, 0);
        xfer(32'h0000_0020, 1'b1, 1'b1, 32'h5555_5555, 4'hF, 1);
        xfer(32'h0000_0020, 1'b1, 1'b0, 32'h0, 4'hF, 0);

        // Reset while a B read is being held off by its agent.
        wait_cycles = 100;
        host_if.address = 32'h0001_0008;
        host_if.read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("b_read_in_issue", 32'(b_if.read), 1);
        #2 rst = 1'b1;
        #1;
        chk("b_read_drops_on_rst", 32'(b_if.read), 0);
        chk("waitrequest_in_rst", 32'(host_if.waitrequest), 1);
        do_reset();
        xfer(32'h0000_0000, 1'b1, 1'b0, 32'h0, 4'hF, 0);

        xfer(32'h0000_0000, 1'b1, 1'b0, 32'h0, 4'hF, 0);
        xfer(32'h0001_0000, 1'b1, 1'b0, 32'h0, 4'hF, 0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: a = {19'd0, 11'($urandom_range(0, 2047)), 2'b00};
                1: a = 32'h0001_0000 | {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                2: a = $urandom & 32'hFFFF_FFFC;
                default: a = edges[$urandom_range(0, 5)];
            endcase
            k = $urandom_range(0, 3);
            xfer(a, k != 2, k >= 2, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
